// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: walks each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK and halts on illegal encodings or memory timeouts.
module multicycle_control_fsm #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        zero,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_source,
    output logic [3:0]  alu_operation,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        illegal_instr,
    output logic        bus_error,
    output logic [2:0]  state_dbg
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         op_q, op_d;
    logic [2:0]         fn3_q, fn3_d;
    logic [6:0]         fn7_q, fn7_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;

    logic               is_alu_r, is_alu_i, is_load, is_store, is_branch;
    logic               fn7_ok, dec_legal, dec_alu_src, br_taken, timed_out;
    logic [3:0]         dec_alu_op, fn3_alu_op;

    // Register/operand fields of the instruction are not needed by the sequencer.
    logic               instr_unused;
    assign instr_unused = ^{instr[24:15], instr[11:7]};

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Shared fn3 -> ALU op mapping for R-type and I-ALU classes.
    always_comb begin
        fn3_alu_op = ALU_ADD;
        unique case (fn3_q)
            3'b000:  fn3_alu_op = (is_alu_r && fn7_q[5]) ? ALU_SUB : ALU_ADD;
            3'b111:  fn3_alu_op = ALU_AND;
            3'b110:  fn3_alu_op = ALU_OR;
            3'b100:  fn3_alu_op = ALU_XOR;
            3'b010:  fn3_alu_op = ALU_SLT;
            3'b001:  fn3_alu_op = ALU_SLL;
            3'b101:  fn3_alu_op = fn7_q[5] ? ALU_SRA : ALU_SRL;
            default: fn3_alu_op = ALU_ADD;
        endcase
    end

    // Classify the latched opcode/fn3/fn7 copy.
    always_comb begin
        is_alu_r    = (op_q == OP_R);
        is_alu_i    = (op_q == OP_I);
        is_load     = (op_q == OP_LOAD);
        is_store    = (op_q == OP_STORE);
        is_branch   = (op_q == OP_BRANCH);
        fn7_ok      = (fn7_q == 7'b0000000) || (fn7_q == 7'b0100000);
        dec_legal   = 1'b0;
        dec_alu_src = 1'b0;
        dec_alu_op  = ALU_ADD;
        br_taken    = 1'b0;
        if (is_alu_r) begin
            dec_legal  = fn7_ok && (fn3_q != 3'b011);
            dec_alu_op = fn3_alu_op;
        end else if (is_alu_i) begin
            dec_legal   = (fn3_q != 3'b011) &&
                          (((fn3_q != 3'b001) && (fn3_q != 3'b101)) || fn7_ok);
            dec_alu_src = 1'b1;
            dec_alu_op  = fn3_alu_op;
        end else if (is_load || is_store) begin
            dec_legal   = 1'b1;
            dec_alu_src = 1'b1;
        end else if (is_branch) begin
            dec_legal  = (fn3_q == 3'b000) || (fn3_q == 3'b001);
            dec_alu_op = ALU_SUB;
            br_taken   = (fn3_q == 3'b000) ? zero : ~zero;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            cnt_q     <= '0;
            op_q      <= '0;
            fn3_q     <= '0;
            fn7_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            fn3_q     <= fn3_d;
            fn7_q     <= fn7_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next state, wait counter and per-state datapath enables.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        fn3_d         = fn3_q;
        fn7_d         = fn7_q;
        illegal_d     = illegal_q;
        bus_err_d     = bus_err_q;
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        alu_source    = 1'b0;
        alu_operation = 4'b0000;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    op_d     = instr[6:0];
                    fn3_d    = instr[14:12];
                    fn7_d    = instr[31:25];
                    state_d  = ST_DECODE;
                end else if (timed_out) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    state_d = ST_EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_EXECUTE: begin
                alu_source    = dec_alu_src;
                alu_operation = dec_alu_op;
                if (is_branch) begin
                    pc_write = 1'b1;
                    pc_src   = br_taken;
                    state_d  = ST_FETCH;
                end else if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEM: begin
                alu_source    = dec_alu_src;
                alu_operation = dec_alu_op;
                mem_read      = is_load;
                mem_write     = ~is_load;
                if (dmem_ready) begin
                    if (is_load) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end else if (timed_out) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITEBACK: begin
                alu_source    = dec_alu_src;
                alu_operation = dec_alu_op;
                reg_write     = 1'b1;
                pc_write      = 1'b1;
                mem_to_reg    = is_load;
                state_d       = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Every wait window starts from zero.
        if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM))) begin
            cnt_d = '0;
        end

        // Reset forces a quiet interface even mid-instruction.
        if (reset) begin
            imem_req      = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_src        = 1'b0;
            alu_source    = 1'b0;
            alu_operation = 4'b0000;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
        end
    end

    assign illegal_instr = illegal_q & ~reset;
    assign bus_error     = bus_err_q & ~reset;
    assign state_dbg     = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm: full output vector
// compared every cycle against hand-computed expectations.
module tb_multicycle_control_fsm;

    localparam int unsigned TIMEOUT = 15;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_XOR = 4'b0011;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SRA = 4'b1000;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_BAD  = 32'h0000007F;
    localparam logic [31:0] I_MUL  = 32'h022081B3;

    logic        clk = 1'b0;
    logic        reset, imem_req, imem_ready, dmem_ready, zero;
    logic [31:0] instr;
    logic        ir_write, pc_write, pc_src, alu_source;
    logic [3:0]  alu_operation;
    logic        mem_read, mem_write, mem_to_reg, reg_write;
    logic        illegal_instr, bus_error;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control_fsm #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .instr(instr), .imem_req(imem_req),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .zero(zero),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_source(alu_source), .alu_operation(alu_operation),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal_instr(illegal_instr),
        .bus_error(bus_error), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
        end
    endtask

    // {state, req, irw, pcw, pcs, asrc, aop, mr, mw, m2r, rw, ill, be}
    function automatic logic [17:0] obs();
        return {state_dbg, imem_req, ir_write, pc_write, pc_src, alu_source, alu_operation,
                mem_read, mem_write, mem_to_reg, reg_write, illegal_instr, bus_error};
    endfunction

    function automatic logic [17:0] ev(input int st, input int req, input int irw, input int pcw,
                                       input int pcs, input int asrc, input logic [3:0] aop,
                                       input int mr, input int mw, input int m2r, input int rw,
                                       input int ill, input int be);
        return {3'(st), 1'(req), 1'(irw), 1'(pcw), 1'(pcs), 1'(asrc), aop,
                1'(mr), 1'(mw), 1'(m2r), 1'(rw), 1'(ill), 1'(be)};
    endfunction

    // Called just after a falling edge with inputs already applied.
    task automatic step(input string tag, input logic [17:0] exp);
        #1;
        check_eq(tag, 32'(obs()), 32'(exp));
        @(negedge clk);
    endtask

    task automatic fetch_decode(input string tag, input logic [31:0] w);
        instr      = w;
        imem_ready = 1'b1;
        step({tag, "_fetch"}, ev(0, 1, 1, 0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0));
        imem_ready = 1'b0;
        step({tag, "_decode"}, ev(1, 0, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic alu_instr(input string tag, input logic [31:0] w, input int asrc,
                             input logic [3:0] aop);
        fetch_decode(tag, w);
        step({tag, "_exec"}, ev(2, 0, 0, 0, 0, asrc, aop, 0, 0, 0, 0, 0, 0));
        step({tag, "_wb"},   ev(4, 0, 0, 1, 0, asrc, aop, 0, 0, 0, 1, 0, 0));
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        step({tag, "_in_reset"}, 18'd0);
        reset      = 1'b0;
        imem_ready = 1'b0;
        step({tag, "_after_reset"}, ev(0, 1, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        reset      = 1'b1;
        instr      = 32'h0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        zero       = 1'b0;
        @(negedge clk);
        step("reset_quiet", 18'd0);
        reset      = 1'b0;
        dmem_ready = 1'b0;

        // R-type and I-ALU classes
        alu_instr("add",   I_ADD,        0, A_ADD);
        alu_instr("sub",   32'h402081B3, 0, A_SUB);
        alu_instr("and",   32'h0020F1B3, 0, A_AND);
        alu_instr("sra_r", 32'h4020D1B3, 0, A_SRA);
        alu_instr("srai",  32'h4030D093, 1, A_SRA);
        alu_instr("xori",  32'h00A0C093, 1, A_XOR);
        alu_instr("addi_neg", 32'hFFF08093, 1, A_ADD);

        // Load with a stray dmem_ready during FETCH and three data wait cycles
        imem_ready = 1'b0;
        dmem_ready = 1'b1;
        step("lw_fetch_wait", ev(0, 1, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0));
        dmem_ready = 1'b0;
        fetch_decode("lw", I_LW);
        step("lw_exec", ev(2, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            step($sformatf("lw_mem%0d", i), ev(3, 0, 0, 0, 0, 1, A_ADD, 1, 0, 0, 0, 0, 0));
        end
        dmem_ready = 1'b0;
        step("lw_wb", ev(4, 0, 0, 1, 0, 1, A_ADD, 0, 0, 1, 1, 0, 0));

        // Branches
        fetch_decode("beq_t", I_BEQ);
        zero = 1'b1;
        step("beq_t_exec", ev(2, 0, 0, 1, 1, 0, A_SUB, 0, 0, 0, 0, 0, 0));
        fetch_decode("beq_nt", I_BEQ);
        zero = 1'b0;
        step("beq_nt_exec", ev(2, 0, 0, 1, 0, 0, A_SUB, 0, 0, 0, 0, 0, 0));
        fetch_decode("bne_t", I_BNE);
        step("bne_t_exec", ev(2, 0, 0, 1, 1, 0, A_SUB, 0, 0, 0, 0, 0, 0));

        // Store whose ready lands on the last allowed wait cycle
        fetch_decode("sw_late", I_SW);
        step("sw_late_exec", ev(2, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            dmem_ready = (i == int'(TIMEOUT) - 1);
            step($sformatf("sw_late_mem%0d", i),
                 ev(3, 0, 0, (i == int'(TIMEOUT) - 1) ? 1 : 0, 0, 1, A_ADD, 0, 1, 0, 0, 0, 0));
        end
        dmem_ready = 1'b0;
        step("sw_late_back", ev(0, 1, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0));

        // Store that never sees ready -> bus error halt
        fetch_decode("sw_to", I_SW);
        step("sw_to_exec", ev(2, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            step($sformatf("sw_to_mem%0d", i), ev(3, 0, 0, 0, 0, 1, A_ADD, 0, 1, 0, 0, 0, 0));
        end
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("sw_to_halt%0d", i), ev(5, 0, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 1));
        end
        dmem_ready = 1'b0;
        do_reset("sw_to");

        // Illegal opcode and illegal R-type fn7
        fetch_decode("bad_op", I_BAD);
        for (int i = 0; i < 2; i++) begin
            step($sformatf("bad_op_halt%0d", i), ev(5, 0, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0, 1, 0));
        end
        do_reset("bad_op");
        fetch_decode("mul", I_MUL);
        step("mul_halt", ev(5, 0, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0, 1, 0));
        do_reset("mul");

        // Reset arriving while a store waits in MEM
        fetch_decode("sw_rst", I_SW);
        step("sw_rst_exec", ev(2, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0, 0, 0, 0));
        step("sw_rst_mem", ev(3, 0, 0, 0, 0, 1, A_ADD, 0, 1, 0, 0, 0, 0));
        dmem_ready = 1'b1;
        do_reset("sw_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
